// File: rtl/mole_scheduler_if.sv
// rtl/mole_scheduler_if.sv - control/status bundle between the mole scheduler and its game logic
// The master drives start/hit; the slave (scheduler) drives position and game status.
interface mole_scheduler_if;
  logic       start;
  logic       hit;
  logic [3:0] pos;
  logic [7:0] score;
  logic [3:0] misses;
  logic [7:0] round;
  logic       busy;
  logic       game_over;

  modport master (
    output start, hit,
    input  pos, score, misses, round, busy, game_over
  );

  modport slave (
    input  start, hit,
    output pos, score, misses, round, busy, game_over
  );
endinterface

// File: rtl/mole_scheduler.sv
// rtl/mole_scheduler.sv - whack-a-mole round sequencer
// Picks mole positions, times gap/show windows, scores judge hits and ends the game.
module mole_scheduler #(
  parameter int         TICK_DIV  = 50000,
  parameter int         GAP_TICKS = 300,
  parameter int         SHOW_INIT = 1000,
  parameter int         SHOW_MIN  = 300,
  parameter int         SHOW_STEP = 100,
  parameter int         MAX_MISS  = 3,
  parameter int         ROUNDS    = 50,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic             clk,
  input logic             rst,
  mole_scheduler_if.slave bus
);
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (GAP_TICKS > SHOW_INIT) ? GAP_TICKS : SHOW_INIT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [3:0] POS_CLEAR = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_GAP   = 3'd2,
    S_SHOW  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [TW-1:0] show_len_q, show_len_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    round_q, round_d;
  logic [3:0]    misses_q, misses_d;
  logic [3:0]    prev_pos_q, prev_pos_d;
  logic [3:0]    pos_q, pos_d;
  logic          busy_q, busy_d;
  logic          over_q, over_d;
  logic [3:0]    cand_raw, cand;
  logic          tick_last, end_round;

  // Never show the same hole twice in a row: bump a repeated pick to the next hole.
  always_comb begin
    cand_raw = 4'(lfsr_q % 8'd9) + 4'd1;
    if (cand_raw == prev_pos_q) begin
      cand = (cand_raw == 4'd9) ? 4'd1 : cand_raw + 4'd1;
    end else begin
      cand = cand_raw;
    end
  end

  assign tick_last = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    round_d    = round_q;
    misses_d   = misses_q;
    show_len_d = show_len_q;
    prev_pos_d = prev_pos_q;
    presc_d    = '0;
    tick_d     = '0;
    end_round  = 1'b0;
    lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          score_d    = '0;
          misses_d   = '0;
          round_d    = '0;
          show_len_d = TW'(SHOW_INIT);
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_GAP;
      S_GAP: begin
        if (tick_last && tick_q == TW'(GAP_TICKS - 1)) begin
          prev_pos_d = cand;
          state_d    = S_SHOW;
        end
      end
      S_SHOW: begin
        // A hit sampled on the expiry edge still counts as a hit.
        if (bus.hit) begin
          score_d   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          round_d   = round_q + 8'd1;
          end_round = 1'b1;
          if (score_d[1:0] == 2'b00) begin
            if (int'(show_len_q) >= SHOW_MIN + SHOW_STEP) begin
              show_len_d = show_len_q - TW'(SHOW_STEP);
            end else begin
              show_len_d = TW'(SHOW_MIN);
            end
          end
        end else if (tick_last && tick_q == show_len_q - TW'(1)) begin
          misses_d  = misses_q + 4'd1;
          round_d   = round_q + 8'd1;
          end_round = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (end_round) begin
      state_d = (misses_d == 4'(MAX_MISS) || round_d == 8'(ROUNDS)) ? S_OVER : S_CLEAR;
    end

    // Timer only runs while staying in a timed state; any state change restarts it.
    if ((state_q == S_GAP || state_q == S_SHOW) && state_d == state_q) begin
      if (tick_last) begin
        tick_d = tick_q + TW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
        tick_d  = tick_q;
      end
    end

    case (state_d)
      S_CLEAR: pos_d = POS_CLEAR;
      S_SHOW:  pos_d = prev_pos_d;
      default: pos_d = 4'd0;
    endcase
    busy_d = (state_d == S_CLEAR) || (state_d == S_GAP) || (state_d == S_SHOW);
    over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      tick_q     <= '0;
      show_len_q <= TW'(SHOW_INIT);
      lfsr_q     <= LFSR_SEED;
      score_q    <= '0;
      round_q    <= '0;
      misses_q   <= '0;
      prev_pos_q <= '0;
      pos_q      <= '0;
      busy_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      show_len_q <= show_len_d;
      lfsr_q     <= lfsr_d;
      score_q    <= score_d;
      round_q    <= round_d;
      misses_q   <= misses_d;
      prev_pos_q <= prev_pos_d;
      pos_q      <= pos_d;
      busy_q     <= busy_d;
      over_q     <= over_d;
    end
  end

  assign bus.pos       = pos_q;
  assign bus.score     = score_q;
  assign bus.misses    = misses_q;
  assign bus.round     = round_q;
  assign bus.busy      = busy_q;
  assign bus.game_over = over_q;
endmodule

// File: tb/tb_mole_scheduler.sv
// tb/tb_mole_scheduler.sv - randomized scoreboard bench for mole_scheduler
// Driver predicts each round's outcome from the game rules; a monitor checks the pos stream.
module tb_mole_scheduler;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 2;
  localparam int SHOW_INIT = 5;
  localparam int SHOW_MIN  = 2;
  localparam int SHOW_STEP = 1;
  localparam int MAX_MISS  = 3;
  localparam int ROUNDS    = 10;
  localparam logic [7:0] SEED = 8'hA5;
  localparam int GAP_CYC   = GAP_TICKS * TICK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mole_scheduler_if bus();

  mole_scheduler #(
    .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS), .SHOW_INIT(SHOW_INIT),
    .SHOW_MIN(SHOW_MIN), .SHOW_STEP(SHOW_STEP), .MAX_MISS(MAX_MISS),
    .ROUNDS(ROUNDS), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int dur;
    int score;
    int misses;
    int rnd;
    bit over;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_score, m_miss, m_round, m_show_len;
  bit   m_over;
  logic [7:0] m_lfsr, lfsr_last;
  int   m_prev, phase, cnt, mole_exp;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic int pick(input logic [7:0] l, input int prev);
    int c;
    c = int'(l) % 9 + 1;
    if (c == prev) c = (c == 9) ? 1 : c + 1;
    return c;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  // Monitor: follows CLEAR -> GAP -> SHOW and checks each round end against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   p;
    p = int'(bus.pos);
    if (rst) begin
      phase  = 0;
      cnt    = 0;
      m_prev = 0;
    end else begin
      case (phase)
        0: if (p == 11) phase = 1;
        1: begin
          chk("clear_len", p, 0);
          cnt   = 1;
          phase = (p == 0) ? 2 : 0;
        end
        2: begin
          if (p == 0) begin
            cnt++;
            if (cnt > 4 * GAP_CYC) begin
              chk("gap_timeout", cnt, GAP_CYC);
              phase = 0;
            end
          end else begin
            chk("gap_len", cnt, GAP_CYC);
            mole_exp = pick(lfsr_last, m_prev);
            chk("mole_pos", p, mole_exp);
            chk("mole_repeat", int'(p == m_prev), 0);
            chk("mole_range", int'(p >= 1 && p <= 9), 1);
            m_prev = mole_exp;
            cnt    = 1;
            phase  = 3;
          end
        end
        default: begin
          if (p == mole_exp) begin
            cnt++;
          end else begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_empty: round ended with pos %0d but no round was expected", p);
            end else begin
              e = exp_q.pop_front();
              chk("show_len", cnt, e.dur);
              chk("score", int'(bus.score), e.score);
              chk("misses", int'(bus.misses), e.misses);
              chk("round", int'(bus.round), e.rnd);
              chk("game_over", int'(bus.game_over), int'(e.over));
              chk("busy", int'(bus.busy), int'(!e.over));
              chk("pos_after", p, e.over ? 0 : 11);
            end
            phase = (p == 11) ? 1 : 0;
          end
        end
      endcase
    end
    lfsr_last = m_lfsr;
  end

  task automatic wait_mole(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.pos >= 4'd1 && bus.pos <= 4'd9) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    m_score    = 0;
    m_miss     = 0;
    m_round    = 0;
    m_show_len = SHOW_INIT;
    m_over     = 1'b0;
    chk("start_pos", int'(bus.pos), 11);
    chk("start_busy", int'(bus.busy), 1);
    chk("start_over", int'(bus.game_over), 0);
    chk("start_score", int'(bus.score), 0);
    chk("start_misses", int'(bus.misses), 0);
    chk("start_round", int'(bus.round), 0);
  endtask

  // hit_at: SHOW cycle whose closing edge samples hit; -1 never, -2 on the expiry edge.
  task automatic play_round(input int hit_at_in, input bit gap_hit, input bit start_in_show);
    bit   ok, is_hit;
    exp_t e;
    int   l4, hit_at, waited;
    hit_at = hit_at_in;
    if (gap_hit) begin
      @(negedge clk);
      bus.hit = 1'b1;
      repeat (5) @(negedge clk);
      bus.hit = 1'b0;
    end
    wait_mole(ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL mole_timeout: got no mole within 200 cycles, expected a position 1-9");
      m_over = 1'b1;
      return;
    end
    l4 = m_show_len * TICK_DIV;
    if (hit_at == -2) hit_at = l4 - 1;
    is_hit = (hit_at >= 0) && (hit_at < l4);
    m_round++;
    if (is_hit) begin
      e.dur   = hit_at + 1;
      m_score = (m_score == 255) ? 255 : m_score + 1;
      if (m_score % 4 == 0)
        m_show_len = (m_show_len - SHOW_STEP < SHOW_MIN) ? SHOW_MIN : m_show_len - SHOW_STEP;
    end else begin
      e.dur = l4;
      m_miss++;
    end
    m_over   = (m_miss == MAX_MISS) || (m_round == ROUNDS);
    e.score  = m_score;
    e.misses = m_miss;
    e.rnd    = m_round;
    e.over   = m_over;
    exp_q.push_back(e);

    waited = 0;
    if (is_hit && hit_at == 0) bus.hit = 1'b1;
    if (start_in_show) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      waited = 1;
    end
    if (is_hit && hit_at > 0) begin
      repeat (hit_at - waited) @(negedge clk);
      bus.hit = 1'b1;
    end
    for (int i = 0; i < l4 + 4; i++) begin
      if (!(bus.pos >= 4'd1 && bus.pos <= 4'd9)) break;
      @(negedge clk);
    end
    bus.hit = 1'b0;
    if (bus.pos >= 4'd1 && bus.pos <= 4'd9) begin
      checks++;
      errors++;
      $display("FAIL show_timeout: mole %0d still shown after %0d cycles", bus.pos, l4 + 4);
      m_over = 1'b1;
    end
  endtask

  task automatic random_round();
    int r, h;
    r = int'($urandom_range(0, 9));
    if (r < 7)       h = int'($urandom_range(0, m_show_len * TICK_DIV - 1));
    else if (r == 7) h = -2;
    else if (r == 8) h = int'($urandom_range(0, 23));
    else             h = -1;
    play_round(h, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
  endtask

  initial begin
    bit ok;
    bus.start = 1'b0;
    bus.hit   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pos", int'(bus.pos), 0);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_misses", int'(bus.misses), 0);
    chk("rst_round", int'(bus.round), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_over", int'(bus.game_over), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    start_game();
    while (!m_over) play_round(-1, 1'b0, 1'b0);
    chk("nohit_misses", int'(bus.misses), 3);
    chk("nohit_round", int'(bus.round), 3);
    chk("nohit_over", int'(bus.game_over), 1);
    chk("nohit_pos", int'(bus.pos), 0);

    start_game();
    while (!m_over) play_round(3, 1'b0, 1'b0);
    chk("allhit_score", int'(bus.score), 10);
    chk("allhit_misses", int'(bus.misses), 0);
    chk("allhit_round", int'(bus.round), 10);

    start_game();
    play_round(-2, 1'b0, 1'b0);
    play_round(1, 1'b1, 1'b0);
    play_round(2, 1'b0, 1'b1);
    play_round(-1, 1'b1, 1'b1);
    while (!m_over) random_round();

    for (int g = 0; g < 4; g++) begin
      start_game();
      while (!m_over) random_round();
    end

    start_game();
    play_round(0, 1'b0, 1'b0);
    play_round(1, 1'b0, 1'b0);
    wait_mole(ok);
    chk("pre_rst_mole", int'(ok), 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("midrst_pos", int'(bus.pos), 0);
    chk("midrst_score", int'(bus.score), 0);
    chk("midrst_misses", int'(bus.misses), 0);
    chk("midrst_round", int'(bus.round), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_over", int'(bus.game_over), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_pos", int'(bus.pos), 0);
    chk("postrst_busy", int'(bus.busy), 0);
    chk("sb_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Round sequencer for the whack-a-mole game. Picks a pseudo-random mole position 1–9 and drives it onto the `pos` bus consumed by the hit judge. Times each mole's visible window, scores judge hits and counts misses. Shortens the window as the score grows and ends the game on a miss limit or round limit. Between moles it emits the position code 11 for one cycle, which clears the judge's sticky hit flag.

## Interface
- TICK_DIV, 50000: clk cycles per timing tick (≥1).
- GAP_TICKS, 300: ticks with no mole shown between rounds (≥1).
- SHOW_INIT, 1000: initial mole-visible window, in ticks.
- SHOW_MIN, 300: floor for the visible window, in ticks.
- SHOW_STEP, 100: window reduction applied after every 4th hit, in ticks.
- MAX_MISS, 3: number of misses that ends the game (1–15).
- ROUNDS, 50: number of rounds that ends the game (1–255).
- LFSR_SEED, 8'hA5: nonzero LFSR reset value.
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle pulse that starts a game. Ignored while busy.
- hit, in, 1: level from the hit judge. Stays high once set, until the judge sees pos==11.
- pos, out, 4: 0 = no mole, 1–9 = mole position, 11 = judge clear code.
- score, out, 8: hits this game, saturating at 255.
- misses, out, 4: misses this game.
- round, out, 8: completed rounds this game.
- busy, out, 1: high in CLEAR, GAP and SHOW.
- game_over, out, 1: high in OVER.

## Operation
- Reset: state=IDLE, pos=0, score=0, misses=0, round=0, busy=0, game_over=0, show_len=SHOW_INIT, lfsr=LFSR_SEED, prev_pos=0, tick prescaler=0, tick counter=0.
- LFSR: 8 bits, polynomial x^8+x^6+x^5+x^4+1. It advances every clock in every state.
- Candidate position: c = (lfsr mod 9) + 1. If c == prev_pos, use (c==9 ? 1 : c+1). The result is latched into prev_pos when SHOW is entered.
- Timer: the prescaler and tick counter are cleared on every state entry. A state lasting N ticks lasts exactly N*TICK_DIV cycles.
- IDLE: pos=0. On start, clear score, misses and round, load show_len=SHOW_INIT, and go to CLEAR.
- CLEAR: pos=11 for exactly one cycle, then go to GAP.
- GAP: pos=0 for GAP_TICKS ticks. hit is ignored. Then go to SHOW.
- SHOW: pos = latched position.
  - If hit is sampled high: score+1 (saturating), round+1, end the round.
  - Else, when show_len ticks expire: misses+1, round+1, end the round.
  - If hit and expiry occur on the same edge, the hit wins (no miss).
- End of round: if misses==MAX_MISS or round==ROUNDS (post-increment values), go to OVER. Otherwise go to CLEAR.
- Speed-up: on a hit where the new score is a multiple of 4, show_len = max(show_len − SHOW_STEP, SHOW_MIN). The subtraction must not underflow. The new show_len applies from the next SHOW.
- OVER: pos=0 and game_over=1. score, misses and round hold their values. On start, behave as IDLE+start.
- start while busy is ignored.

## Timing
- All outputs are registered.
- start sampled at edge t → pos=11 and busy=1 in the cycle after t.
- pos=0 follows for GAP_TICKS*TICK_DIV cycles, then the mole position appears.
- hit sampled high at edge h in SHOW → score, round and pos=11 (next CLEAR) all update at edge h. There is no added latency.
- Expiry: the last SHOW cycle is show_len*TICK_DIV cycles after pos was set. misses updates at the same edge as the pos change.
- game_over rises on the edge that ends the final round. pos=0 from then on.
- rst asserted mid-game returns everything to the reset values immediately; no partial round is counted.

## Test plan
Settings: TICK_DIV=4, GAP_TICKS=2, SHOW_INIT=5, SHOW_MIN=2, SHOW_STEP=1, MAX_MISS=3, ROUNDS=10.
- Start with no hits ever → pos=11 for 1 cycle, 0 for 8 cycles, a position in 1–9 for 20 cycles, then a miss. After 3 rounds: misses=3, round=3, game_over=1, pos=0.
- Assert hit 3 cycles into every SHOW, deasserting it on pos==11 → score increments per round. show_len goes 5→4 at score 4 and 4→3 at score 8. Game ends at round=10 with score=10, misses=0.
- Raise hit on the exact edge the window expires → score+1, misses unchanged.
- Hold hit high during GAP → no score change.
- Pulse start during SHOW → no effect on state or counters. Pulse start in OVER → counters clear, pos=11 next cycle.
- Assert rst mid-SHOW → all outputs return to their reset values immediately. Across 20 rounds, no two consecutive positions are equal and every position is in 1–9.
